uart_rx8: RTL and testbench

//  8N1 UART receiver; counterpart of uart_tx8 on the same serial link.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_ff.sv | 36 +++
 rtl/uart_rx8.sv | 152 +++++++++++++++
 tb/tb_uart_rx8.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART state encoding and baud divisor helper.
//  Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Brief    : Multi-stage single-bit synchroniser with a configurable preset.
//  Revision : 1.0
// ============================================================================
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_ff: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx8.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx8
//  Brief    : 8N1 UART receiver, mid-bit sampling, valid/ack byte handshake.
//  Revision : 1.0
// ============================================================================
module uart_rx8
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int SYNC_STG = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);
    localparam int c_cnt_w        = $clog2(c_clks_per_bit);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_clks_per_bit / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_clks_per_bit - 1);

    generate
        if (c_clks_per_bit < 4) begin : g_bad_baud
            $error("uart_rx8: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic               w_rx_s;
    uart_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_frame_err;
    logic               r_overrun;

    // Idle line is high, so the synchroniser presets to 1 to avoid a false start.
    sync_ff #(
        .STAGES    (SYNC_STG),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (ack && r_valid) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_cnt_half) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_cnt_full) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_cnt_full) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // A same-cycle ack frees the slot, so the new byte wins.
                            if (!r_valid || ack) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx8
//  Brief    : Self-checking bench for uart_rx8 against a frame-timing model.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx8;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int SYNC   = 2;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ack   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx8 #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .SYNC_STG (SYNC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .ack       (ack),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    // Reference model: frame events are placed at absolute cycle offsets
    // from the detected start edge rather than tracked with bit counters.
    logic [SYNC-1:0] m_sync  = '1;
    int              m_cyc   = 0;
    int              m_t0    = 0;
    int              m_phase = 0;   // 0 idle, 1 in frame, 2 line held low
    logic [7:0]      m_byte  = '0;
    logic [7:0]      m_data  = '0;
    logic            m_valid = 1'b0;
    logic            m_busy  = 1'b0;
    logic            m_fe    = 1'b0;
    logic            m_ov    = 1'b0;

    int         n_pass  = 0;
    int         n_total = 0;
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] recv[$];
    logic [7:0] expq[$];
    bit         auto_ack = 1'b0;
    int         ack_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_loop();
        logic rs;
        int   off;
        int   k;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_sync = '1; m_phase = 0; m_data = '0; m_valid = 1'b0;
                m_busy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_byte = '0;
            end else begin
                rs     = m_sync[SYNC-1];
                m_sync = {m_sync[SYNC-2:0], rx};
                m_cyc++;
                m_fe = 1'b0;
                m_ov = 1'b0;
                if (ack && m_valid) m_valid = 1'b0;
                if (m_phase == 0) begin
                    if (!rs) begin
                        m_phase = 1; m_t0 = m_cyc; m_busy = 1'b1;
                    end
                end else if (m_phase == 1) begin
                    off = m_cyc - m_t0;
                    if (off == HALF && rs) begin
                        m_phase = 0; m_busy = 1'b0;
                    end else if (off > HALF && (off - HALF) % CPB == 0) begin
                        k = (off - HALF) / CPB - 1;
                        if (k < 8) begin
                            m_byte[k] = rs;
                        end else if (rs) begin
                            if (!m_valid) begin
                                m_data = m_byte; m_valid = 1'b1;
                            end else begin
                                m_ov = 1'b1;
                            end
                            m_phase = 0; m_busy = 1'b0;
                        end else begin
                            m_fe = 1'b1; m_phase = 2;
                        end
                    end
                end else if (rs) begin
                    m_phase = 0; m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            chk("data",      {24'd0, data}, {24'd0, m_data});
            chk("valid",     {31'd0, valid}, {31'd0, m_valid});
            chk("busy",      {31'd0, busy}, {31'd0, m_busy});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
            chk("overrun",   {31'd0, overrun}, {31'd0, m_ov});
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (valid === 1'b1 && prev_valid !== 1'b1) recv.push_back(data);
            prev_valid = valid;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (ack) begin
            ack     = 1'b0;
            ack_cnt = $urandom_range(0, 4);
        end else if (auto_ack && valid === 1'b1) begin
            if (ack_cnt == 0) ack = 1'b1;
            else ack_cnt--;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Leaves rx at the stop-bit level so a following frame can start immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack_at_stop);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int j = 0; j < CPB; j++) begin
                tick();
                if (ack_at_stop && m_phase == 1 && (m_cyc - m_t0) == HALF + 9 * CPB - 1)
                    ack = 1'b1;
            end
        end
    endtask

    initial begin
        int         fe0;
        int         ov0;
        logic [7:0] b;
        logic       stop;
        int         r;
        logic [7:0] t5[3];

        fork
            model_loop();
            monitor();
        join_none

        repeat (3) tick();
        chk("reset_data",  {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(5);

        // Single byte with delayed ack
        auto_ack = 1'b1; ack_cnt = 3; recv.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("t1_count", recv.size(), 32'd1);
        if (recv.size() > 0) chk("t1_byte", {24'd0, recv[0]}, 32'hA5);
        chk("t1_valid", {31'd0, valid}, 32'd0);
        chk("t1_busy",  {31'd0, busy}, 32'd0);
        chk("t1_errs",  fe_cnt - fe0 + ov_cnt - ov0, 32'd0);

        // Start-bit glitch
        recv.delete();
        rx = 1'b0;
        repeat (3) tick();
        idle(3 * CPB);
        chk("t2_count", recv.size(), 32'd0);
        chk("t2_busy",  {31'd0, busy}, 32'd0);
        chk("t2_fe",    fe_cnt - fe0, 32'd0);

        // Framing error then held-low line
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (50) tick();
        chk("t3_fe",    fe_cnt - fe0, 32'd1);
        chk("t3_busy",  {31'd0, busy}, 32'd1);
        chk("t3_valid", {31'd0, valid}, 32'd0);
        chk("t3_data",  {24'd0, data}, 32'hA5);
        idle(2 * CPB);
        chk("t3_idle",  {31'd0, busy}, 32'd0);

        // Overrun with no ack
        auto_ack = 1'b0; ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(CPB);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(CPB);
        chk("t4_ov",    ov_cnt - ov0, 32'd1);
        chk("t4_data",  {24'd0, data}, 32'h11);
        chk("t4_valid", {31'd0, valid}, 32'd1);

        // Ack coinciding with the stop sample of the next byte
        ov0 = ov_cnt;
        send_frame(8'h33, 1'b1, 1'b1);
        idle(CPB);
        chk("t4b_data",  {24'd0, data}, 32'h33);
        chk("t4b_valid", {31'd0, valid}, 32'd1);
        chk("t4b_ov",    ov_cnt - ov0, 32'd0);
        ack = 1'b1;
        tick();
        tick();
        chk("t4b_ackd", {31'd0, valid}, 32'd0);

        // Back-to-back frames
        auto_ack = 1'b1; recv.delete();
        t5[0] = 8'h00; t5[1] = 8'hFF; t5[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(t5[i], 1'b1, 1'b0);
        idle(2 * CPB);
        chk("t5_count", recv.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (recv.size() > i) chk("t5_byte", {24'd0, recv[i]}, {24'd0, t5[i]});

        // Reset mid-frame
        b = 8'h77;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        reset = 1'b1;
        #1;
        chk("t6_data",  {24'd0, data}, 32'h00);
        chk("t6_valid", {31'd0, valid}, 32'd0);
        chk("t6_busy",  {31'd0, busy}, 32'd0);
        rx = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle(20);
        recv.delete();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("t6_count", recv.size(), 32'd1);
        if (recv.size() > 0) chk("t6_byte", {24'd0, recv[0]}, 32'h81);

        // Randomised traffic: good frames, bad stop bits and glitches
        recv.delete(); expq.delete();
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                idle($urandom_range(6, 20));
            end else begin
                b    = 8'($urandom);
                stop = (r == 1) ? 1'b0 : 1'b1;
                send_frame(b, stop, 1'b0);
                if (stop) begin
                    expq.push_back(b);
                    idle($urandom_range(0, 12));
                end else begin
                    idle(CPB + $urandom_range(0, 5));
                end
            end
        end
        idle(3 * CPB);
        chk("rnd_count", recv.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (recv.size() > i) chk("rnd_byte", {24'd0, recv[i]}, {24'd0, expq[i]});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
